// File: rtl/mem_wb_pipe_reg.sv
// MEM/WB pipeline register: DEPTH stages of writeback control and data with
// stall/flush, zero-register write suppression, WB data mux and retire counter.
module mem_wb_pipe_reg #(
  parameter int DATA_W          = 32,
  parameter int REG_ADDR_W      = 5,
  parameter int DEPTH           = 1,
  parameter bit ZERO_REG_SQUASH = 1'b1,
  parameter int CNT_W           = 16
) (
  input  logic                  i_Clk,
  input  logic                  i_Rst,
  input  logic                  i_Stall,
  input  logic                  i_Flush,
  input  logic                  i_ValidIn,
  input  logic [1:0]            i_WBin,
  input  logic [DATA_W-1:0]     i_ReadData,
  input  logic [DATA_W-1:0]     i_ALUResult,
  input  logic [REG_ADDR_W-1:0] i_WriteReg,
  output logic                  o_ValidOut,
  output logic                  o_MemtoReg,
  output logic                  o_RegWrite,
  output logic [DATA_W-1:0]     o_ReadDataOut,
  output logic [DATA_W-1:0]     o_ALUResultOut,
  output logic [REG_ADDR_W-1:0] o_WriteRegOut,
  output logic [DATA_W-1:0]     o_WBData,
  output logic [CNT_W-1:0]      o_RetireCount
);

  localparam int LAST = DEPTH - 1;

  if (DEPTH < 1 || DEPTH > 4) begin : g_bad_depth
    $error("mem_wb_pipe_reg: DEPTH must be in 1..4");
  end

  // Handshake: i_ValidIn qualifies the input entry; an entry is accepted on an
  // edge with Stall=0 and Flush=0, and leaves the last stage on an edge with
  // Stall=0 or Flush=1 (a flush edge still performs the pending writeback).
  logic [DEPTH-1:0]                 r_valid;
  logic [DEPTH-1:0]                 r_m2r;
  logic [DEPTH-1:0]                 r_rw;
  logic [DEPTH-1:0][DATA_W-1:0]     r_rd;
  logic [DEPTH-1:0][DATA_W-1:0]     r_alu;
  logic [DEPTH-1:0][REG_ADDR_W-1:0] r_wr;
  logic [CNT_W-1:0]                 r_cnt;

  logic w_retire;
  logic w_zero_dst;

  always_ff @(posedge i_Clk) begin
    if (i_Rst || i_Flush) begin
      r_valid <= '0;
      r_m2r   <= '0;
      r_rw    <= '0;
      r_rd    <= '0;
      r_alu   <= '0;
      r_wr    <= '0;
    end else if (!i_Stall) begin
      r_valid[0] <= i_ValidIn;
      r_m2r[0]   <= i_ValidIn & i_WBin[0];
      r_rw[0]    <= i_ValidIn & i_WBin[1];
      r_rd[0]    <= i_ReadData;
      r_alu[0]   <= i_ALUResult;
      r_wr[0]    <= i_WriteReg;
      for (int i = 1; i < DEPTH; i++) begin
        r_valid[i] <= r_valid[i-1];
        r_m2r[i]   <= r_m2r[i-1];
        r_rw[i]    <= r_rw[i-1];
        r_rd[i]    <= r_rd[i-1];
        r_alu[i]   <= r_alu[i-1];
        r_wr[i]    <= r_wr[i-1];
      end
    end
  end

  assign w_retire = ~i_Rst & r_valid[LAST] & (~i_Stall | i_Flush);

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      r_cnt <= '0;
    end else if (w_retire) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign w_zero_dst     = ZERO_REG_SQUASH && (r_wr[LAST] == '0);
  assign o_ValidOut     = r_valid[LAST];
  assign o_MemtoReg     = r_valid[LAST] & r_m2r[LAST];
  assign o_RegWrite     = r_valid[LAST] & r_rw[LAST] & ~w_zero_dst;
  assign o_ReadDataOut  = r_rd[LAST];
  assign o_ALUResultOut = r_alu[LAST];
  assign o_WriteRegOut  = r_wr[LAST];
  assign o_WBData       = o_MemtoReg ? r_rd[LAST] : r_alu[LAST];
  assign o_RetireCount  = r_cnt;

endmodule

// File: tb/tb_mem_wb_pipe_reg.sv
// Bench for mem_wb_pipe_reg: three configurations share one stimulus stream,
// each checked every cycle against a queue-based reference of in-flight entries.
module tb_mem_wb_pipe_reg;

  typedef struct packed {
    logic        valid;
    logic        m2r;
    logic        rw;
    logic [31:0] rd;
    logic [31:0] alu;
    logic [4:0]  wr;
  } ent_t;

  typedef struct packed {
    logic        valid;
    logic        m2r;
    logic        rw;
    logic [31:0] rd;
    logic [31:0] alu;
    logic [4:0]  wr;
    logic [31:0] wb;
    logic [15:0] cnt;
  } exp_t;

  localparam int EXP_W = $bits(exp_t);
  typedef ent_t ent_q_t[$];

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1, stall = 1'b0, flush = 1'b0, vin = 1'b0;
  logic [1:0]  wbin = 2'b00;
  logic [31:0] rdata = '0, alu = '0;
  logic [4:0]  wreg = '0;

  logic        a_v, a_m, a_r, b_v, b_m, b_r, c_v, c_m, c_r;
  logic [31:0] a_rd, a_alu, a_wb, b_rd, b_alu, b_wb, c_rd, c_alu, c_wb;
  logic [4:0]  a_wr, b_wr, c_wr;
  logic [3:0]  a_cnt;
  logic [15:0] b_cnt, c_cnt;

  mem_wb_pipe_reg #(.DATA_W(32), .REG_ADDR_W(5), .DEPTH(1), .ZERO_REG_SQUASH(1'b1), .CNT_W(4)) dut_a (
    .i_Clk(clk), .i_Rst(rst), .i_Stall(stall), .i_Flush(flush), .i_ValidIn(vin),
    .i_WBin(wbin), .i_ReadData(rdata), .i_ALUResult(alu), .i_WriteReg(wreg),
    .o_ValidOut(a_v), .o_MemtoReg(a_m), .o_RegWrite(a_r), .o_ReadDataOut(a_rd),
    .o_ALUResultOut(a_alu), .o_WriteRegOut(a_wr), .o_WBData(a_wb), .o_RetireCount(a_cnt));

  mem_wb_pipe_reg #(.DATA_W(32), .REG_ADDR_W(5), .DEPTH(3), .ZERO_REG_SQUASH(1'b0), .CNT_W(16)) dut_b (
    .i_Clk(clk), .i_Rst(rst), .i_Stall(stall), .i_Flush(flush), .i_ValidIn(vin),
    .i_WBin(wbin), .i_ReadData(rdata), .i_ALUResult(alu), .i_WriteReg(wreg),
    .o_ValidOut(b_v), .o_MemtoReg(b_m), .o_RegWrite(b_r), .o_ReadDataOut(b_rd),
    .o_ALUResultOut(b_alu), .o_WriteRegOut(b_wr), .o_WBData(b_wb), .o_RetireCount(b_cnt));

  mem_wb_pipe_reg #(.DATA_W(32), .REG_ADDR_W(5), .DEPTH(2), .ZERO_REG_SQUASH(1'b1), .CNT_W(16)) dut_c (
    .i_Clk(clk), .i_Rst(rst), .i_Stall(stall), .i_Flush(flush), .i_ValidIn(vin),
    .i_WBin(wbin), .i_ReadData(rdata), .i_ALUResult(alu), .i_WriteReg(wreg),
    .o_ValidOut(c_v), .o_MemtoReg(c_m), .o_RegWrite(c_r), .o_ReadDataOut(c_rd),
    .o_ALUResultOut(c_alu), .o_WriteRegOut(c_wr), .o_WBData(c_wb), .o_RetireCount(c_cnt));

  // reference model: p[0] is the entry at the output, p[$] the youngest
  ent_q_t p_a, p_b, p_c;
  logic [15:0] m_cnt_a = '0, m_cnt_b = '0, m_cnt_c = '0;
  logic [EXP_W-1:0] exp_q_a[$], exp_q_b[$], exp_q_c[$];

  int n_checks = 0;
  int n_err    = 0;

  task automatic model_step(ref ent_q_t p, ref logic [15:0] cnt, input int depth,
                            input logic [15:0] cmask, input bit squash, output exp_t e);
    ent_t z, n;
    z = '0;
    if (rst) begin
      p.delete();
      for (int i = 0; i < depth; i++) p.push_back(z);
      cnt = '0;
    end else begin
      if (p[0].valid && (!stall || flush)) cnt = (cnt + 16'd1) & cmask;
      if (flush) begin
        for (int i = 0; i < depth; i++) p[i] = z;
      end else if (!stall) begin
        n.valid = vin;
        n.m2r   = vin && wbin[0];
        n.rw    = vin && wbin[1];
        n.rd    = rdata;
        n.alu   = alu;
        n.wr    = wreg;
        void'(p.pop_front());
        p.push_back(n);
      end
    end
    e.valid = p[0].valid;
    e.m2r   = p[0].valid && p[0].m2r;
    e.rw    = p[0].valid && p[0].rw && !(squash && p[0].wr == 5'd0);
    e.rd    = p[0].rd;
    e.alu   = p[0].alu;
    e.wr    = p[0].wr;
    e.wb    = e.m2r ? p[0].rd : p[0].alu;
    e.cnt   = cnt;
  endtask

  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      model_step(p_a, m_cnt_a, 1, 16'h000F, 1'b1, e); exp_q_a.push_back(EXP_W'(e));
      model_step(p_b, m_cnt_b, 3, 16'hFFFF, 1'b0, e); exp_q_b.push_back(EXP_W'(e));
      model_step(p_c, m_cnt_c, 2, 16'hFFFF, 1'b1, e); exp_q_c.push_back(EXP_W'(e));
    end
  end

  // scoreboard
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare(input string tag, input exp_t e, input logic v, input logic m,
                         input logic r, input logic [31:0] rd, input logic [31:0] al,
                         input logic [4:0] wr, input logic [31:0] wb, input logic [15:0] cnt);
    check({tag, ".valid"},    {31'b0, v}, {31'b0, e.valid});
    check({tag, ".memtoreg"}, {31'b0, m}, {31'b0, e.m2r});
    check({tag, ".regwrite"}, {31'b0, r}, {31'b0, e.rw});
    check({tag, ".readdata"}, rd, e.rd);
    check({tag, ".aluresult"}, al, e.alu);
    check({tag, ".writereg"}, {27'b0, wr}, {27'b0, e.wr});
    check({tag, ".wbdata"},   wb, e.wb);
    check({tag, ".retire"},   {16'b0, cnt}, {16'b0, e.cnt});
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #2;
      if (exp_q_a.size() > 0)
        compare("a", exp_t'(exp_q_a.pop_front()), a_v, a_m, a_r, a_rd, a_alu, a_wr, a_wb, {12'b0, a_cnt});
      if (exp_q_b.size() > 0)
        compare("b", exp_t'(exp_q_b.pop_front()), b_v, b_m, b_r, b_rd, b_alu, b_wr, b_wb, b_cnt);
      if (exp_q_c.size() > 0)
        compare("c", exp_t'(exp_q_c.pop_front()), c_v, c_m, c_r, c_rd, c_alu, c_wr, c_wb, c_cnt);
    end
  end

  // driver
  task automatic drive(input logic r, input logic s, input logic f, input logic v,
                       input logic [1:0] w, input logic [31:0] d, input logic [31:0] a,
                       input logic [4:0] g);
    @(negedge clk);
    rst = r; stall = s; flush = f; vin = v; wbin = w; rdata = d; alu = a; wreg = g;
  endtask

  task automatic bubbles(input int n);
    for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 2'b11, 32'hFFFF_FFFF, 32'h5555_5555, 5'd7);
  endtask

  initial begin
    // reset with nonzero inputs on the bus
    drive(1, 0, 0, 1, 2'b11, 32'hAAAA_AAAA, 32'hBBBB_BBBB, 5'd3);
    drive(1, 1, 1, 1, 2'b11, 32'hAAAA_AAAA, 32'hBBBB_BBBB, 5'd3);
    drive(0, 0, 0, 1, 2'b10, 32'h0, 32'h0000_1234, 5'd5);
    bubbles(4);
    // load path through the deeper configurations
    drive(0, 0, 0, 1, 2'b11, 32'hDEAD_BEEF, 32'h10, 5'd9);
    bubbles(4);
    // A, B, stall while B is at the DEPTH=1 output, then C
    drive(0, 0, 0, 1, 2'b10, 32'h0, 32'hA, 5'd1);
    drive(0, 0, 0, 1, 2'b10, 32'h0, 32'hB, 5'd2);
    for (int i = 0; i < 3; i++) drive(0, 1, 0, 1, 2'b11, 32'h0, 32'hEEEE, 5'd4);
    drive(0, 0, 0, 1, 2'b10, 32'h0, 32'hC, 5'd3);
    bubbles(4);
    // flush together with stall while two valid entries are in flight
    drive(0, 0, 0, 1, 2'b10, 32'h0, 32'h21, 5'd6);
    drive(0, 0, 0, 1, 2'b11, 32'h22, 32'h0, 5'd7);
    drive(0, 1, 1, 1, 2'b10, 32'h0, 32'h23, 5'd8);
    bubbles(4);
    // zero-register destination
    drive(0, 0, 0, 1, 2'b10, 32'h0, 32'h77, 5'd0);
    bubbles(4);
    // counter wrap: 17 retirements after a fresh reset, then valid-less bubbles
    drive(1, 0, 0, 0, 2'b00, 32'h0, 32'h0, 5'd0);
    for (int i = 0; i < 17; i++) drive(0, 0, 0, 1, 2'b10, 32'h0, 32'(i), 5'(i + 1));
    bubbles(6);
    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      drive(($urandom_range(0, 59) == 0), ($urandom_range(0, 4) == 0),
            ($urandom_range(0, 11) == 0), ($urandom_range(0, 3) != 0),
            2'($urandom_range(0, 3)), $urandom, $urandom,
            ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31)));
    end
    // mid-stream reset, then drain
    drive(0, 0, 0, 1, 2'b11, 32'h1, 32'h2, 5'd3);
    drive(1, 0, 0, 1, 2'b11, 32'h4, 32'h5, 5'd6);
    bubbles(3);
    @(negedge clk);
    check("queue_a_drained", 32'(exp_q_a.size()), 32'd0);
    check("queue_b_drained", 32'(exp_q_b.size()), 32'd0);
    check("queue_c_drained", 32'(exp_q_c.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/mem_wb_pipe_reg.md
Name: mem_wb_pipe_reg

Overview:
Parametrised MEM/WB pipeline register. Carries writeback control and data from the MEM stage to the register file over DEPTH register stages. Adds per-entry valid tracking, stall (hold) and flush (bubble) control, synchronous reset of all state, and zero-register write suppression. Also drives a muxed writeback data bus and a retired-instruction counter. It sits between data memory and the register-file write port of the SAD datapath.

Parameters:
DATA_W, 32, width of ReadData/ALUResult/writeback data
REG_ADDR_W, 5, register-file address width
DEPTH, 1, number of register stages (legal 1..4); latency in cycles
ZERO_REG_SQUASH, 1, when 1, RegWrite is forced low for destination register 0
CNT_W, 16, width of retired-instruction counter

Ports:
Clk  in  1  clock; all state updates on rising edge
Rst  in  1  synchronous, active-high reset
Stall  in  1  hold all stages
Flush  in  1  kill all in-flight entries
ValidIn  in  1  input entry is a real instruction
WBin  in  2  [0]=MemtoReg, [1]=RegWrite
ReadData  in  DATA_W  memory load data
ALUResult  in  DATA_W  ALU result
WriteReg  in  REG_ADDR_W  destination register
ValidOut  out  1  last stage holds a valid entry
MemtoReg  out  1  last-stage MemtoReg, gated by valid
RegWrite  out  1  last-stage RegWrite, gated by valid and zero-reg squash
ReadDataOut  out  DATA_W  last-stage ReadData
ALUResultOut  out  DATA_W  last-stage ALUResult
WriteRegOut  out  REG_ADDR_W  last-stage WriteReg
WBData  out  DATA_W  MemtoReg ? ReadDataOut : ALUResultOut
RetireCount  out  CNT_W  count of retired valid entries

Behaviour:
- Stage i holds {valid, MemtoReg, RegWrite, ReadData, ALUResult, WriteReg}. Stage 0 loads from the inputs. Stage DEPTH-1 drives the outputs. Latency is DEPTH cycles.
- Priority at each rising edge: Rst > Flush > Stall > advance.
- Rst=1: every stage field cleared to 0; RetireCount=0. All outputs read 0 in the next cycle, including WBData, ValidOut and RegWrite.
- Flush=1 (Rst=0): every stage cleared to 0 (bubbles), regardless of Stall. The input entry presented that cycle is discarded.
- Stall=1 (Rst=0, Flush=0): all stages hold their values. Inputs are ignored. Outputs are unchanged.
- Advance (Rst=0, Flush=0, Stall=0): stage0 <= inputs; stage i <= stage i-1.
- If ValidIn=0, stage 0 loads valid=0 and both control bits as 0. Data fields are still captured.
- Output gating (combinational from the last stage):
  - MemtoReg = valid & m2r.
  - RegWrite = valid & rw & ~(ZERO_REG_SQUASH && WriteRegOut==0).
  - Data outputs are unmasked register values.
- WBData is combinational from last-stage registers. It adds no extra latency.
- RetireCount increments by 1 at an edge when Rst=0, last-stage valid=1, and (Stall=0 or Flush=1). The entry is counted once when it leaves the stage. A flush edge still retires the entry already presented at the output, because its writeback occurs at that same edge.
- A held entry under Stall is not recounted.
- RetireCount wraps from 2^CNT_W-1 to 0 and does not saturate.
- Reset asserted mid-stream discards all entries; no retirement is counted on the reset edge.
- DEPTH outside 1..4 is a configuration error; the implementation flags it with an elaboration-time check.

Test Plan:
- Reset: Rst=1 for 2 cycles with nonzero inputs -> all outputs 0, RetireCount=0. Release; ValidIn=1, WBin=2'b10, ALUResult=0x0000_1234, WriteReg=5 -> next cycle RegWrite=1, MemtoReg=0, WBData=0x1234, WriteRegOut=5, RetireCount=0. One edge later RetireCount=1.
- Load path, DEPTH=3: ValidIn=1, WBin=2'b11, ReadData=0xDEAD_BEEF, ALUResult=0x10, WriteReg=9 -> outputs appear exactly 3 cycles later with WBData=0xDEADBEEF.
- Stall: stream entries A,B,C at DEPTH=1; assert Stall for 3 cycles while B is at the output -> B held for 3 cycles and counted once. After release C appears. RetireCount goes 1 (A), then 2 (B), then 3 (C) on the corresponding leaving edges.
- Flush with Stall: DEPTH=2 with 2 valid entries, Stall=1 and Flush=1 together -> next cycle ValidOut=0, RegWrite=0. RetireCount increments by 1 for the output entry only. The following cycle ValidOut is also 0.
- Zero-reg squash: WBin=2'b10, WriteReg=0, ValidIn=1 -> RegWrite=0 and ValidOut=1 (with ZERO_REG_SQUASH=1). With ZERO_REG_SQUASH=0 -> RegWrite=1.
- Counter wrap, CNT_W=4: retire 17 valid entries -> RetireCount=1. Bubble inputs (ValidIn=0) never increment the counter.
